// File: rtl/ddr3_app_pkg.sv
// ddr3_app_pkg: constants and state type shared by the app-interface
// responder and the app-interface master.
//   WT_CMD / RD_CMD : app command encodings
//   APP_*_W         : app bus widths
//   app_state_e     : responder FSM states
package ddr3_app_pkg;
  localparam int APP_ADDR_W = 27;
  localparam int APP_DATA_W = 128;
  localparam int APP_MASK_W = 16;

  localparam logic [2:0] WT_CMD = 3'd0;
  localparam logic [2:0] RD_CMD = 3'd1;

  typedef enum logic [2:0] {CALIB, IDLE, WRITE, RD_WAIT, READ} app_state_e;
endpackage

// File: rtl/ddr3_app_if.sv
// ddr3_app_if: DDR3 controller user ("app") command / write / read bus.
//   master : drives commands and write beats, consumes read beats
//   slave  : the memory side (responder)
interface ddr3_app_if;
  import ddr3_app_pkg::*;

  logic                  app_cmd_en;
  logic [2:0]            app_cmd;
  logic [APP_ADDR_W-1:0] app_addr;
  logic [5:0]            app_burst_number;
  logic                  app_cmd_ready;
  logic [APP_DATA_W-1:0] app_wdata;
  logic                  app_wdata_en;
  logic                  app_wdata_end;
  logic [APP_MASK_W-1:0] app_wdata_mask;
  logic                  app_wdata_ready;
  logic [APP_DATA_W-1:0] app_rdata;
  logic                  app_rdata_valid;
  logic                  app_rdata_end;
  logic                  init_calib_complete;

  modport master (
    output app_cmd_en, app_cmd, app_addr, app_burst_number,
           app_wdata, app_wdata_en, app_wdata_end, app_wdata_mask,
    input  app_cmd_ready, app_wdata_ready, app_rdata, app_rdata_valid,
           app_rdata_end, init_calib_complete
  );

  modport slave (
    input  app_cmd_en, app_cmd, app_addr, app_burst_number,
           app_wdata, app_wdata_en, app_wdata_end, app_wdata_mask,
    output app_cmd_ready, app_wdata_ready, app_rdata, app_rdata_valid,
           app_rdata_end, init_calib_complete
  );
endinterface

// File: rtl/app_mem_sdp.sv
// app_mem_sdp: simple dual-port RAM, 2^AW words of NUM_LANES byte lanes,
// per-lane write enable, registered read port.
//   clk, rstn : clock, async active-low reset (read register only)
//   we/waddr/wdata : write port, one enable per lane
//   re/raddr       : read request; data appears on rdata next cycle
//   rdata          : registered read data, held when re is low
// Contents are not touched by reset; they come up zero from configuration.
module app_mem_sdp #(
  parameter int AW        = 10,
  parameter int NUM_LANES = 16,
  parameter int VEC_W     = 8
)(
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [NUM_LANES-1:0]                we,
  input  logic [AW-1:0]                       waddr,
  input  logic [NUM_LANES-1:0][VEC_W-1:0]     wdata,
  input  logic                                re,
  input  logic [AW-1:0]                       raddr,
  output logic [NUM_LANES-1:0][VEC_W-1:0]     rdata
);
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [VEC_W-1:0] ram [2**AW];
    logic [VEC_W-1:0] q;

    always_ff @(posedge clk)
      if (we[l]) ram[waddr] <= wdata[l];

    always_ff @(posedge clk or negedge rstn)
      if (!rstn)   q <= '0;
      else if (re) q <= ram[raddr];

    assign rdata[l] = q;
  end
endmodule

// File: rtl/ddr3_app_responder.sv
// ddr3_app_responder: BRAM-backed stand-in for a DDR3 controller app port.
//   clk, rstn : clock, async active-low reset
//   io        : app bus (slave side): commands, masked write beats,
//               fixed-latency read beats, init_calib_complete
//   err       : sticky protocol-violation flag, cleared only by reset
// Bursts of 1..64 beats address mem[(base+k) mod 2^MEM_AW]; the first read
// beat appears RD_LATENCY cycles after the command fires.
module ddr3_app_responder import ddr3_app_pkg::*; #(
  parameter int MEM_AW       = 10,
  parameter int RD_LATENCY   = 4,
  parameter int CALIB_CYCLES = 16
)(
  input  logic        clk,
  input  logic        rstn,
  ddr3_app_if.slave   io,
  output logic        err
);
  localparam int CW = $clog2(CALIB_CYCLES + 1);
  localparam int LW = $clog2(RD_LATENCY);

  app_state_e        state;
  logic [CW-1:0]     cal_cnt;
  logic [LW-1:0]     lat_cnt;
  logic [MEM_AW-1:0] base;
  logic [6:0]        beats, wcnt, rcnt;
  logic              calib_done, rd_vld;

  logic              cmd_ready, wdata_ready, cmd_ok, fire, wr_fire, rd_fire;
  logic              beat_fire, last_wbeat, rd_issue, err_set;
  logic [6:0]        cmd_beats;
  logic [MEM_AW-1:0] cmd_base, wr_addr, rd_addr;

  assign cmd_ready   = (state == IDLE);
  assign wdata_ready = (state == IDLE) || (state == WRITE);
  assign cmd_ok      = (io.app_cmd == WT_CMD) || (io.app_cmd == RD_CMD);
  assign fire        = io.app_cmd_en && cmd_ready && cmd_ok;
  assign wr_fire     = fire && (io.app_cmd == WT_CMD);
  assign rd_fire     = fire && (io.app_cmd == RD_CMD);
  assign cmd_beats   = {1'b0, io.app_burst_number} + 7'd1;
  assign cmd_base    = io.app_addr[MEM_AW+2:3];

  // A beat in IDLE is only legal alongside its own write command (beat 0).
  assign beat_fire  = io.app_wdata_en && ((state == WRITE) || wr_fire);
  assign wr_addr    = wr_fire ? cmd_base : base + MEM_AW'(wcnt);
  assign last_wbeat = wr_fire ? (cmd_beats == 7'd1) : (wcnt == beats - 7'd1);

  // Reads are issued one cycle ahead of rdata_valid (registered RAM port):
  // the first in the last RD_WAIT cycle, the rest while READ has beats left.
  assign rd_issue = ((state == RD_WAIT) && (lat_cnt == '0)) ||
                    ((state == READ) && (rcnt != beats));
  assign rd_addr  = base + MEM_AW'(rcnt);

  assign err_set = (io.app_cmd_en && !cmd_ready) ||
                   (io.app_cmd_en && cmd_ready && !cmd_ok) ||
                   (io.app_wdata_en && !beat_fire);

  app_mem_sdp #(.AW(MEM_AW), .NUM_LANES(APP_MASK_W), .VEC_W(8)) u_mem (
    .clk   (clk),
    .rstn  (rstn),
    .we    (beat_fire ? ~io.app_wdata_mask : '0),
    .waddr (wr_addr),
    .wdata (io.app_wdata),
    .re    (rd_issue),
    .raddr (rd_addr),
    .rdata (io.app_rdata)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= CALIB;
      cal_cnt    <= '0;
      lat_cnt    <= '0;
      base       <= '0;
      beats      <= '0;
      wcnt       <= '0;
      rcnt       <= '0;
      calib_done <= 1'b0;
      rd_vld     <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (err_set) err <= 1'b1;
      rd_vld <= rd_issue;
      if (rd_issue) rcnt <= rcnt + 7'd1;
      case (state)
        CALIB: begin
          cal_cnt <= cal_cnt + 1'b1;
          if (cal_cnt == CW'(CALIB_CYCLES - 1)) begin
            calib_done <= 1'b1;
            state      <= IDLE;
          end
        end
        IDLE: begin
          if (fire) begin
            base  <= cmd_base;
            beats <= cmd_beats;
          end
          if (rd_fire) begin
            lat_cnt <= LW'(RD_LATENCY - 2);
            rcnt    <= '0;
            state   <= RD_WAIT;
          end else if (wr_fire) begin
            wcnt  <= beat_fire ? 7'd1 : 7'd0;
            state <= (beat_fire && last_wbeat) ? IDLE : WRITE;
          end
        end
        WRITE: begin
          if (beat_fire) begin
            wcnt <= wcnt + 7'd1;
            if (last_wbeat) state <= IDLE;
          end
        end
        RD_WAIT: begin
          if (lat_cnt == '0) state   <= READ;
          else               lat_cnt <= lat_cnt - 1'b1;
        end
        READ: begin
          // No issue this cycle means the last beat is on the bus now.
          if (rcnt == beats) state <= IDLE;
        end
        default: state <= CALIB;
      endcase
    end
  end

  assign io.app_cmd_ready       = cmd_ready;
  assign io.app_wdata_ready     = wdata_ready;
  assign io.app_rdata_valid     = rd_vld;
  assign io.app_rdata_end       = rd_vld;
  assign io.init_calib_complete = calib_done;

  // Inputs the responder deliberately ignores.
  logic unused_in;
  assign unused_in = ^{io.app_wdata_end, io.app_addr[APP_ADDR_W-1:MEM_AW+3],
                       io.app_addr[2:0]};
endmodule

// File: tb/tb_ddr3_app_responder.sv
module tb_ddr3_app_responder;
  import ddr3_app_pkg::*;

  localparam int AW = 10, DEPTH = 1 << AW, RDL = 4, CAL = 16;

  logic clk = 1'b0, rstn = 1'b0, err;
  ddr3_app_if app();

  ddr3_app_responder #(.MEM_AW(AW), .RD_LATENCY(RDL), .CALIB_CYCLES(CAL)) dut (
    .clk(clk), .rstn(rstn), .io(app), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  int n_cmp = 0, n_bad = 0;
  logic [127:0] model [DEPTH];
  logic [127:0] wbuf [64];
  logic [15:0]  mbuf [64];
  logic [127:0] rbuf [64];

  typedef struct {
    logic [26:0]  waddr;
    logic [26:0]  raddr;
    logic [127:0] wdata;
    logic [15:0]  mask;
    logic [127:0] exp;
  } vec_t;
  vec_t vecs [5];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    app.app_cmd_en = 0; app.app_cmd = WT_CMD; app.app_addr = '0;
    app.app_burst_number = '0; app.app_wdata = '0; app.app_wdata_en = 0;
    app.app_wdata_end = 0; app.app_wdata_mask = '0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (app.app_cmd_ready !== 1'b1 && n < 300) begin tick(); n++; end
    if (n >= 300) check("cmd_ready_timeout", 128'(app.app_cmd_ready), 128'(1));
  endtask

  // Reset, check reset values, release, check calibration timing.
  task automatic do_reset();
    int first = -1;
    rstn = 0; idle_in(); #3;
    check("reset_flags", 128'({app.app_cmd_ready, app.app_wdata_ready, app.app_rdata_valid,
                               app.app_rdata_end, app.init_calib_complete, err}), 128'(0));
    check("reset_rdata", app.app_rdata, 128'(0));
    @(posedge clk); #1; rstn = 1;
    for (int k = 1; k <= CAL + 3; k++) begin
      tick();
      if (first < 0 && app.init_calib_complete === 1'b1) first = k;
      if (k == CAL - 1)
        check("calib_flags_low", 128'({app.init_calib_complete, app.app_cmd_ready, app.app_wdata_ready}), 128'(0));
      if (k == CAL)
        check("calib_flags_high", 128'({app.init_calib_complete, app.app_cmd_ready, app.app_wdata_ready}), 128'(3'b111));
    end
    check("calib_first_cycle", 128'(first), 128'(CAL));
    check("err_after_reset", 128'(err), 128'(0));
  endtask

  // Write nb beats from wbuf/mbuf; beat 0 optionally in the command cycle.
  task automatic do_write(input logic [26:0] addr, input int nb, input bit in_fire, input int maxgap);
    int k = 0;
    int base = int'(addr[AW+2:3]);
    wait_ready();
    app.app_cmd_en = 1; app.app_cmd = WT_CMD; app.app_addr = addr;
    app.app_burst_number = 6'(nb - 1);
    if (in_fire) begin
      app.app_wdata_en = 1; app.app_wdata = wbuf[0]; app.app_wdata_mask = mbuf[0];
      app.app_wdata_end = (nb == 1); k = 1;
    end
    tick();
    app.app_cmd_en = 0; app.app_wdata_en = 0;
    while (k < nb) begin
      repeat ($urandom_range(0, maxgap)) tick();
      app.app_wdata_en = 1; app.app_wdata = wbuf[k]; app.app_wdata_mask = mbuf[k];
      app.app_wdata_end = (k == nb - 1);
      tick();
      app.app_wdata_en = 0; k++;
    end
    check("wr_done_ready", 128'(app.app_cmd_ready), 128'(1));
    for (int i = 0; i < nb; i++)
      for (int j = 0; j < 16; j++)
        if (!mbuf[i][j]) model[(base + i) % DEPTH][j*8 +: 8] = wbuf[i][j*8 +: 8];
  endtask

  // Read nb beats into rbuf and check timing and data against the model.
  // inject: protocol violations during READ. rst_at: assert reset at that cycle.
  task automatic do_read(input logic [26:0] addr, input int nb, input bit inject, input int rst_at);
    int base = int'(addr[AW+2:3]);
    int first = -1, nv = 0, bad = 0, endbad = 0;
    logic [127:0] g0 = '0, e0 = '0;
    wait_ready();
    app.app_cmd_en = 1; app.app_cmd = RD_CMD; app.app_addr = addr;
    app.app_burst_number = 6'(nb - 1);
    tick();
    app.app_cmd_en = 0;
    for (int k = 1; k <= RDL + nb; k++) begin
      if (app.app_rdata_end !== app.app_rdata_valid) endbad++;
      if (app.app_rdata_valid === 1'b1) begin
        if (first < 0) first = k;
        if (nv < 64) begin
          rbuf[nv] = app.app_rdata;
          if (nv == 0) begin g0 = app.app_rdata; e0 = model[base % DEPTH]; end
          if (app.app_rdata !== model[(base + nv) % DEPTH]) begin
            if (bad == 0) begin g0 = app.app_rdata; e0 = model[(base + nv) % DEPTH]; end
            bad++;
          end
        end
        nv++;
      end
      if (rst_at == k) begin
        rstn = 0; #1;
        check("rst_rvalid_drop", 128'(app.app_rdata_valid), 128'(0));
        return;
      end
      if (k == RDL + nb) check("rd_ready_after", 128'(app.app_cmd_ready), 128'(1));
      if (inject && k == RDL + 1) begin
        app.app_cmd_en = 1; app.app_cmd = WT_CMD; app.app_addr = addr; app.app_burst_number = '0;
        app.app_wdata_en = 1; app.app_wdata = {4{32'hBAD0BAD0}}; app.app_wdata_mask = '0;
      end else begin
        app.app_cmd_en = 0; app.app_wdata_en = 0;
      end
      if (k < RDL + nb) tick();
    end
    check("rd_first_latency", 128'(first), 128'(RDL));
    check("rd_beat_count", 128'(nv), 128'(nb));
    check("rd_data", g0, e0);
    check("rd_end_eq_valid", 128'(endbad), 128'(0));
  endtask

  initial begin
    logic [26:0] a;
    logic [7:0]  bb;
    int nb;

    vecs[0] = '{27'h40, 27'h40, 128'h0123456789ABCDEF0123456789ABCDEF, 16'h0000,
                128'h0123456789ABCDEF0123456789ABCDEF};
    vecs[1] = '{27'h40, 27'h40, {128{1'b1}}, 16'h00FF,
                128'hFFFFFFFFFFFFFFFF0123456789ABCDEF};
    vecs[2] = '{27'h48, 27'h4C, {8{16'hA5A5}}, 16'hFFFF, 128'h0};
    vecs[3] = '{27'h1FF8, 27'h1FF8, 128'h11223344556677889900AABBCCDDEEFF, 16'h5555,
                128'h11003300550077009900AA00CC00EE00};
    vecs[4] = '{27'h4000050, 27'h0000050, 128'hDEADBEEFCAFEF00D0000000012345678, 16'h0000,
                128'hDEADBEEFCAFEF00D0000000012345678};

    idle_in();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    do_reset();

    // Bring the whole RAM to a known zero state.
    for (int i = 0; i < 64; i++) begin wbuf[i] = '0; mbuf[i] = '0; end
    for (int b = 0; b < DEPTH / 64; b++) do_write(27'(b * 64 * 8), 64, (b % 2) == 1, 0);

    // Single-beat vectors with hand-derived expectations.
    for (int i = 0; i < 5; i++) begin
      wbuf[0] = vecs[i].wdata; mbuf[0] = vecs[i].mask;
      do_write(vecs[i].waddr, 1, 1, 0);
      do_read(vecs[i].raddr, 1, 0, 0);
      check($sformatf("vec%0d", i), rbuf[0], vecs[i].exp);
    end

    // 4-beat burst at 0 with gaps, beat 2 masked to bytes 0..3.
    for (int k = 0; k < 4; k++) begin
      bb = 8'(k + 1); wbuf[k] = {16{bb}}; mbuf[k] = (k == 1) ? 16'hFFF0 : 16'h0000;
    end
    do_write(27'h0, 4, 0, 3);
    do_read(27'h0, 4, 0, 0);
    check("burst_b1", rbuf[0], {16{8'h01}});
    check("burst_b2", rbuf[1], 128'h02020202);
    check("burst_b3", rbuf[2], {16{8'h03}});
    check("burst_b4", rbuf[3], {16{8'h04}});

    // Wrap from index 1023 to index 0.
    wbuf[0] = {8{16'hAAAA}}; wbuf[1] = {8{16'h5A5A}}; mbuf[0] = '0; mbuf[1] = '0;
    do_write(27'(1023 * 8), 2, 1, 2);
    do_read(27'h0, 1, 0, 0);
    check("wrap_idx0", rbuf[0], {8{16'h5A5A}});
    do_read(27'(1023 * 8), 2, 0, 0);
    check("wrap_idx1023", rbuf[0], {8{16'hAAAA}});

    // Randomized traffic against the array model.
    for (int t = 0; t < 40; t++) begin
      a  = 27'($urandom);
      nb = ($urandom_range(0, 9) == 0) ? 64 : int'($urandom_range(1, 8));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < nb; i++) begin
          wbuf[i] = {$urandom, $urandom, $urandom, $urandom};
          mbuf[i] = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'h0000;
        end
        do_write(a, nb, $urandom_range(0, 1) == 1, 2);
      end else begin
        do_read(a, nb, 0, 0);
      end
    end
    check("err_clean_traffic", 128'(err), 128'(0));

    // Violations during READ: read still completes, err sticky, memory intact.
    for (int i = 0; i < 3; i++) begin wbuf[i] = {4{32'(32'h1000 + i)}}; mbuf[i] = '0; end
    do_write(27'h100, 3, 0, 1);
    do_read(27'h100, 3, 1, 0);
    check("err_cmd_in_read", 128'(err), 128'(1));
    repeat (5) tick();
    check("err_sticky", 128'(err), 128'(1));
    do_read(27'h100, 3, 0, 0);
    do_reset();

    // Write beat in IDLE with no command.
    app.app_wdata_en = 1; app.app_wdata = {4{32'hDEAD0001}}; app.app_wdata_mask = '0;
    tick();
    app.app_wdata_en = 0;
    tick();
    check("err_wdata_idle", 128'(err), 128'(1));
    check("ready_after_bad_wdata", 128'(app.app_cmd_ready), 128'(1));
    do_read(27'h0, 4, 0, 0);
    do_read(27'h100, 3, 0, 0);
    do_reset();

    // Illegal command encoding is dropped.
    app.app_cmd_en = 1; app.app_cmd = 3'd5; app.app_addr = 27'h100; app.app_burst_number = '0;
    tick();
    app.app_cmd_en = 0;
    check("err_bad_cmd", 128'(err), 128'(1));
    check("ready_after_bad_cmd", 128'(app.app_cmd_ready), 128'(1));

    // Reset in the middle of a 64-beat read, then data survives recalibration.
    do_read(27'h100, 64, 0, RDL + 10);
    do_reset();
    do_read(27'h100, 3, 0, 0);
    check("post_reset_b0", rbuf[0], {4{32'h1000}});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
